switch_debouncer: RTL and testbench
===================================

// Module: switch_debouncer
// PURPOSE
//   Input conditioning stage for the board slide switches. Synchronises each
//   raw switch into the clk domain, filters contact bounce, and produces clean
//   levels plus one-cycle edge pulses. Sits directly upstream of the 4:1 mux:
//   sw_db[3:0] drive the mux data inputs and sw_db[5:4] drive its select.
// PARAMETERS
//   WIDTH    6        number of switch bits filtered independently
//   CNT_MAX  1000000  consecutive stable cycles required to accept a change
//                     (10 ms at 100 MHz); legal range >= 1
// PORTS
//   clk      in   1      system clock, all logic on rising edge
//   rst      in   1      asynchronous reset, active-high
//   sw_raw   in   WIDTH  raw switch inputs, asynchronous to clk
//   sw_db    out  WIDTH  debounced switch levels
//   sw_rise  out  WIDTH  one-cycle pulse when sw_db bit goes 0->1
//   sw_fall  out  WIDTH  one-cycle pulse when sw_db bit goes 1->0
// BEHAVIOUR
//   Reset: clk single clock; rst asynchronous, active-high. While rst=1,
//     sync1, sync2, all counters, sw_db, sw_rise and sw_fall are 0. Assertion
//     mid-operation clears them immediately, without waiting for a clk edge.
//     Counts and pending changes are discarded. After release, the filter
//     restarts from sw_db=0.
//   Sync: per bit 2-FF synchroniser sync1 <= sw_raw, sync2 <= sync1.
//     Only sync2 feeds the filter.
//   Counter: per bit, CW = $clog2(CNT_MAX+1) bits wide.
//     Each edge, sync2 == sw_db: cnt <= 0.
//     sync2 != sw_db and cnt < CNT_MAX-1: cnt <= cnt+1.
//     sync2 != sw_db and cnt == CNT_MAX-1: sw_db <= sync2, cnt <= 0.
//     The counter never wraps.
//   Latency: raw change is stable before edge E1. sync2 changes at E2. sw_db
//     changes at edge E(2+CNT_MAX). CNT_MAX=1 gives 3 edges total.
//   Glitch rejection: a sync2 excursion shorter than CNT_MAX cycles returns
//     cnt to 0, and sw_db does not change. A bounce resets the count, so the
//     count restarts from 0 after the last bounce.
//   Edges: registered. sw_rise = 1 exactly in the cycle after the edge at
//     which sw_db rose, and 0 otherwise. sw_fall is the same for falling.
//     rise and fall of one bit are never high together.
//   Bits are independent. Simultaneous changes on several bits each follow
//     their own counter. Different bits may update on different edges.
//   No handshake: outputs are level/pulse, valid every cycle after reset.
// TESTING  (WIDTH=6, CNT_MAX=4, 10 ns clk)
//   1 Reset: rst=1 with sw_raw=6'h3F -> sw_db=0 and rise/fall=0 throughout.
//     Release rst -> sw_db=6'h3F at edge 6 after release, sw_rise=6'h3F for
//     one cycle.
//   2 Clean step: sw_raw[0] 0->1 before E1 -> sw_db[0]=1 exactly after E6.
//     sw_rise[0]=1 in the cycle after E6 only. Other bits unchanged.
//   3 Glitch: sw_raw[2] high for 3 cycles then low -> sw_db[2] stays 0.
//     No pulse.
//   4 Bounce: sw_raw[5] toggles 1,0,1,0,1 at one-cycle spacing, then stays 1
//     -> sw_db[5]=1 at 2+4 edges after the final rising toggle, single
//     sw_rise pulse.
//   5 Mux sweep: drive sw_raw[5:4]=00..11 with the matching data bit high ->
//     sw_db follows each step after 6 edges, and the mux led0 matches.
//   6 Reset mid-count: sw_raw[1] rises, rst pulsed at cnt=2 -> sw_db[1]=0.
//     After release it needs a full 6-edge delay to set.

Source files
------------

// File: rtl/switch_debouncer.sv
// Per-bit 2-FF synchroniser, stable-count debounce filter and registered edge pulses.
// Latency CNT_MAX+2 edges from raw change to sw_db; no backpressure, outputs valid every cycle.
module switch_debouncer #(
    parameter int WIDTH   = 6,
    parameter int CNT_MAX = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall
);

    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_db;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_db_nxt;
    logic [CW-1:0]    w_cnt_nxt [WIDTH];

    // Any cycle where the synchronised input agrees with the accepted level
    // restarts the count, so only an unbroken run of CNT_MAX disagreements commits.
    always_comb begin
        w_db_nxt = r_db;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_sync2[i] != r_db[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_db_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_rise  <= '0;
            r_fall  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= sw_raw;
            r_sync2 <= r_sync1;
            r_db    <= w_db_nxt;
            r_rise  <= w_db_nxt & ~r_db;
            r_fall  <= ~w_db_nxt & r_db;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign sw_db   = r_db;
    assign sw_rise = r_rise;
    assign sw_fall = r_fall;

endmodule

// File: tb/tb_switch_debouncer.sv
// Randomised and directed stimulus for switch_debouncer, checked by a window-based reference model.
module tb_switch_debouncer;

    localparam int WIDTH   = 6;
    localparam int CNT_MAX = 4;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic [WIDTH-1:0] sw_raw = 6'h3F;
    logic [WIDTH-1:0] sw_db;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;

    typedef struct packed {
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } exp_t;

    exp_t expq[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    switch_debouncer #(.WIDTH(WIDTH), .CNT_MAX(CNT_MAX)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_raw  (sw_raw),
        .sw_db   (sw_db),
        .sw_rise (sw_rise),
        .sw_fall (sw_fall)
    );

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a level is accepted when the last CNT_MAX synchronised
    // samples (since reset) all agree on a value that differs from the current level.
    logic [WIDTH-1:0] m_s1 = '0;
    logic [WIDTH-1:0] m_s2 = '0;
    logic [WIDTH-1:0] m_db = '0;
    logic [WIDTH-1:0] win[$];

    always @(posedge clk) begin
        exp_t             e;
        logic [WIDTH-1:0] nd;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_db = '0;
            win.delete();
            e = '0;
        end else begin
            win.push_back(m_s2);
            if (win.size() > CNT_MAX) void'(win.pop_front());
            nd = m_db;
            if (win.size() == CNT_MAX) begin
                for (int i = 0; i < WIDTH; i++) begin
                    bit agree;
                    agree = 1'b1;
                    for (int k = 1; k < CNT_MAX; k++) begin
                        if (win[k][i] != win[0][i]) agree = 1'b0;
                    end
                    if (agree && (win[0][i] != m_db[i])) nd[i] = win[0][i];
                end
            end
            e.db   = nd;
            e.rise = nd & ~m_db;
            e.fall = ~nd & m_db;
            m_db   = nd;
            m_s2   = m_s1;
            m_s1   = sw_raw;
        end
        expq.push_back(e);
    end

    // Monitor: outputs are valid every cycle, so one expectation is consumed per cycle.
    always @(negedge clk) begin
        exp_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            check("sw_db",   sw_db,   e.db);
            check("sw_rise", sw_rise, e.rise);
            check("sw_fall", sw_fall, e.fall);
            check("mux_led0", {5'b0, sw_db[sw_db[5:4]]}, {5'b0, e.db[e.db[5:4]]});
        end
    end

    task automatic set_raw(input logic [WIDTH-1:0] v);
        @(posedge clk);
        #2;
        sw_raw = v;
    endtask

    // Counts edges until the given bit of sw_db sets; the raw change must precede the next edge.
    task automatic measure(input int b, input string name);
        int n;
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            n = k;
            if (sw_db[b]) break;
        end
        if (!sw_db[b]) n = 99;
        n_vec++;
        if (n != CNT_MAX + 2) begin
            n_err++;
            $display("FAIL %s: latency %0d edges, expected %0d", name, n, CNT_MAX + 2);
        end
    endtask

    initial begin
        // Reset held with all switches high
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_hold", sw_db | sw_rise | sw_fall, 6'h00);
        rst = 1'b0;
        measure(0, "reset_release_latency");

        // Clean step
        set_raw(6'h00);
        repeat (10) @(posedge clk);
        set_raw(6'h01);
        measure(0, "clean_step_latency");
        repeat (4) @(posedge clk);

        // Glitch of 3 cycles on bit 2
        set_raw(6'h05);
        repeat (2) @(posedge clk);
        set_raw(6'h01);
        repeat (10) @(posedge clk);

        // Bounce on bit 5
        set_raw(6'h21);
        set_raw(6'h01);
        set_raw(6'h21);
        set_raw(6'h01);
        set_raw(6'h21);
        measure(5, "bounce_latency");
        repeat (4) @(posedge clk);

        // Mux sweep: select each data input with its bit high
        for (int s = 0; s < 4; s++) begin
            logic [3:0] d;
            logic [1:0] sel;
            d   = 4'b0001 << s;
            sel = 2'(s);
            set_raw({sel, d});
            repeat (8) @(posedge clk);
        end

        // Asynchronous reset mid-count on bit 1
        set_raw(6'h00);
        repeat (10) @(posedge clk);
        set_raw(6'h02);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("async_reset_clear", sw_db | sw_rise | sw_fall, 6'h00);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        measure(1, "post_reset_latency");

        // Random hold lengths straddling the acceptance threshold
        repeat (80) begin
            set_raw(6'($urandom));
            repeat ($urandom_range(0, 9)) @(posedge clk);
        end

        set_raw(6'h00);
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
